// File: rtl/mult_pkg.sv
// Shared constants and control payload for the mult_pipe multiplier.
package mult_pkg;

  localparam logic [1:0] MULT_OP_MUL  = 2'b00;
  localparam logic [1:0] MULT_OP_MADD = 2'b01;
  localparam logic [1:0] MULT_OP_MSUB = 2'b10;
  localparam logic [1:0] MULT_OP_RSV  = 2'b11;

  localparam int MULT_MAX_STAGES = 3;

  // Per-stage control carried alongside the data payload.
  typedef struct packed {
    logic       valid;
    logic       neg;
    logic [1:0] op;
  } mult_ctl_t;

  // The reserved encoding behaves as a plain multiply.
  function automatic logic [1:0] mult_norm_op(input logic [1:0] op);
    return (op == MULT_OP_RSV) ? MULT_OP_MUL : op;
  endfunction

endpackage

// File: rtl/mult_pp_unit.sv
// Unsigned HW x HW partial-product multiplier; four of these form one full-width product.
module mult_pp_unit #(
  parameter int HW = 16
) (
  input  logic [HW-1:0]   i_a,
  input  logic [HW-1:0]   i_b,
  output logic [2*HW-1:0] o_p
);

  assign o_p = {{HW{1'b0}}, i_a} * {{HW{1'b0}}, i_b};

endmodule

// File: rtl/mult_pipe.sv
// Pipelined signed/unsigned WIDTH x WIDTH multiplier with valid/ready handshake and flush.
// Optional accumulate modes (MADD/MSUB) are built when MULT_ACC_EN is defined.
module mult_pipe
  import mult_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
`ifdef MULT_ACC_EN
  input  logic [1:0]         in_op,
  input  logic [2*WIDTH-1:0] acc_in,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_result
);

  localparam int HW = WIDTH / 2;

  if (STAGES < 1 || STAGES > MULT_MAX_STAGES) begin : g_bad_stages
    $error("mult_pipe: STAGES must be 1, 2 or 3");
  end
  if ((WIDTH % 2) != 0 || WIDTH < 8 || WIDTH > 64) begin : g_bad_width
    $error("mult_pipe: WIDTH must be even and within 8..64");
  end

  typedef struct packed {
    mult_ctl_t          ctl;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc;
  } mag_pl_t;

  // partials: [3]=hi*hi, [2]=hi*lo, [1]=lo*hi, [0]=lo*lo
  typedef struct packed {
    mult_ctl_t               ctl;
    logic [3:0][WIDTH-1:0]   partials;
    logic [2*WIDTH-1:0]      acc;
  } pp_pl_t;

  // Handshake: a stage register loads only when w_adv=1; every stage moves together.
  // in_ready mirrors w_adv, so an input transfers on in_valid & w_adv, and the
  // output transfers on out_valid & out_ready. flush clears all valids and wins over w_adv.
  logic               w_adv;
  logic               r_out_valid;
  logic [2*WIDTH-1:0] r_out_result;

  mag_pl_t            w_sa;
  mag_pl_t            w_sb;
  pp_pl_t             w_sp;
  pp_pl_t             w_sc;
  logic [WIDTH-1:0]   w_pp_ll;
  logic [WIDTH-1:0]   w_pp_lh;
  logic [WIDTH-1:0]   w_pp_hl;
  logic [WIDTH-1:0]   w_pp_hh;
  logic [2*WIDTH-1:0] w_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_res;

  assign w_adv      = !r_out_valid || out_ready;
  assign in_ready   = w_adv;
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;

  // Magnitudes: negating the most-negative value yields 2^(WIDTH-1) as unsigned, no overflow.
  always_comb begin
    w_sa           = '0;
    w_sa.ctl.valid = in_valid;
    w_sa.ctl.neg   = in_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
    w_sa.mag_a     = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
    w_sa.mag_b     = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
`ifdef MULT_ACC_EN
    w_sa.ctl.op    = mult_norm_op(in_op);
    w_sa.acc       = acc_in;
`else
    w_sa.ctl.op    = MULT_OP_MUL;
    w_sa.acc       = '0;
`endif
  end

  if (STAGES == 3) begin : g_mag_reg
    mag_pl_t r_s1;
    always_ff @(posedge clk) begin
      if (!resetn)     r_s1.ctl.valid <= 1'b0;
      else if (flush)  r_s1.ctl.valid <= 1'b0;
      else if (w_adv)  r_s1 <= w_sa;
    end
    assign w_sb = r_s1;
  end else begin : g_mag_bypass
    assign w_sb = w_sa;
  end

  mult_pp_unit #(.HW(HW)) u_pp_ll (.i_a(w_sb.mag_a[HW-1:0]),     .i_b(w_sb.mag_b[HW-1:0]),     .o_p(w_pp_ll));
  mult_pp_unit #(.HW(HW)) u_pp_lh (.i_a(w_sb.mag_a[HW-1:0]),     .i_b(w_sb.mag_b[WIDTH-1:HW]), .o_p(w_pp_lh));
  mult_pp_unit #(.HW(HW)) u_pp_hl (.i_a(w_sb.mag_a[WIDTH-1:HW]), .i_b(w_sb.mag_b[HW-1:0]),     .o_p(w_pp_hl));
  mult_pp_unit #(.HW(HW)) u_pp_hh (.i_a(w_sb.mag_a[WIDTH-1:HW]), .i_b(w_sb.mag_b[WIDTH-1:HW]), .o_p(w_pp_hh));

  always_comb begin
    w_sp          = '0;
    w_sp.ctl      = w_sb.ctl;
    w_sp.acc      = w_sb.acc;
    w_sp.partials = {w_pp_hh, w_pp_hl, w_pp_lh, w_pp_ll};
  end

  if (STAGES >= 2) begin : g_pp_reg
    pp_pl_t r_s2;
    always_ff @(posedge clk) begin
      if (!resetn)     r_s2.ctl.valid <= 1'b0;
      else if (flush)  r_s2.ctl.valid <= 1'b0;
      else if (w_adv)  r_s2 <= w_sp;
    end
    assign w_sc = r_s2;
  end else begin : g_pp_bypass
    assign w_sc = w_sp;
  end

  // Cross terms sit HW bits up; the true magnitude product always fits in 2*WIDTH bits.
  always_comb begin
    w_sum  = {w_sc.partials[3], w_sc.partials[0]}
           + {{HW{1'b0}}, w_sc.partials[2], {HW{1'b0}}}
           + {{HW{1'b0}}, w_sc.partials[1], {HW{1'b0}}};
    w_prod = w_sc.ctl.neg ? -w_sum : w_sum;
    unique case (w_sc.ctl.op)
      MULT_OP_MADD: w_res = w_sc.acc + w_prod;
      MULT_OP_MSUB: w_res = w_sc.acc - w_prod;
      default:      w_res = w_prod;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
    end else begin
      if (flush)      r_out_valid <= 1'b0;
      else if (w_adv) r_out_valid <= w_sc.ctl.valid;
      if (w_adv)      r_out_result <= w_res;
    end
  end

endmodule

// File: tb/tb_mult_pipe.sv
// Self-checking bench for mult_pipe: directed corner cases plus randomized traffic against a queue model.
module tb_mult_pipe;

  localparam int W = 32;
  localparam int S = 3;

  logic           clk;
  logic           resetn;
  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic           in_signed;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
`ifdef MULT_ACC_EN
  logic [1:0]     in_op;
  logic [2*W-1:0] acc_in;
`endif
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_result;

  mult_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_signed  (in_signed),
    .in_a       (in_a),
    .in_b       (in_b),
`ifdef MULT_ACC_EN
    .in_op      (in_op),
    .acc_in     (acc_in),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: expected results in order, with the number of advancing edges each op has seen
  logic [2*W-1:0] exp_q[$];
  int             cnt_q[$];
  logic [2*W-1:0] drv_exp;
  int             n_checks;
  int             n_pass;
  bit             chk_en;
  bit             chk_zero;

  task automatic check(input string tag, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Reference: full-width product of sign- or zero-extended operands, then optional accumulate
  function automatic logic [2*W-1:0] ref_res(input logic s, input logic [W-1:0] a,
                                              input logic [W-1:0] b, input logic [1:0] op,
                                              input logic [2*W-1:0] acc);
    logic [2*W-1:0] ea, eb, p;
    ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    p  = ea * eb;
    case (op)
      2'b01:   return acc + p;
      2'b10:   return acc - p;
      default: return p;
    endcase
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return W'(1);
      2: return {W{1'b1}};
      3: return {1'b1, {(W-1){1'b0}}};
      4: return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  // Driver tasks
  task automatic drive_idle();
    in_valid  = 1'b0;
    in_signed = 1'b0;
    in_a      = '0;
    in_b      = '0;
`ifdef MULT_ACC_EN
    in_op     = 2'b00;
    acc_in    = '0;
`endif
  endtask

  task automatic drive_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid  = 1'b1;
    in_signed = s;
    in_a      = a;
    in_b      = b;
`ifdef MULT_ACC_EN
    in_op     = 2'b00;
    acc_in    = {W'($urandom), W'($urandom)};
`endif
    drv_exp   = ref_res(s, a, b, 2'b00, '0);
  endtask

  task automatic drive_lit(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2*W-1:0] lit);
    drive_op(s, a, b);
    drv_exp = lit;
  endtask

`ifdef MULT_ACC_EN
  task automatic drive_acc(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [1:0] op, input logic [2*W-1:0] acc);
    in_valid  = 1'b1;
    in_signed = s;
    in_a      = a;
    in_b      = b;
    in_op     = op;
    acc_in    = acc;
    drv_exp   = ref_res(s, a, b, op, acc);
  endtask
`endif

  // One clock: compare outputs mid-cycle, update the model for the coming edge, advance.
  task automatic cycle();
    logic exp_valid;
    logic adv;
    @(negedge clk);
    exp_valid = (exp_q.size() > 0) && (cnt_q[0] >= S);
    if (chk_en) begin
      check("out_valid", (2*W)'(out_valid), (2*W)'(exp_valid));
      check("in_ready", (2*W)'(in_ready), (2*W)'(!exp_valid || out_ready));
      if (exp_valid) check("out_result", out_result, exp_q[0]);
      if (chk_zero)  check("rst_result", out_result, '0);
    end
    chk_zero = 1'b0;
    adv = !exp_valid || out_ready;
    if (!resetn) begin
      exp_q.delete();
      cnt_q.delete();
      chk_en   = 1'b1;
      chk_zero = 1'b1;
    end else if (flush) begin
      exp_q.delete();
      cnt_q.delete();
    end else begin
      if (exp_valid && out_ready) begin
        void'(exp_q.pop_front());
        void'(cnt_q.pop_front());
      end
      if (adv) foreach (cnt_q[i]) cnt_q[i]++;
      if (in_valid && adv) begin
        exp_q.push_back(drv_exp);
        cnt_q.push_back(1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive_idle();
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle();
    check("drain_empty", (2*W)'(exp_q.size()), '0);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    chk_en    = 1'b0;
    chk_zero  = 1'b0;
    drv_exp   = '0;
    resetn    = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive_idle();
    @(posedge clk);
    #1;
    cycle();
    cycle();
    resetn = 1'b1;
    cycle();

    // Spec corner products
    drive_lit(1'b1, 32'hFFFFFFFF, 32'h00000002, 64'hFFFFFFFFFFFFFFFE);
    cycle();
    drive_idle();
    repeat (4) cycle();
    drive_lit(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
    cycle();
    drive_lit(1'b1, 32'h80000000, 32'h7FFFFFFF, 64'hC000000080000000);
    cycle();
    drive_lit(1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000);
    cycle();
    drain();

    // Back-to-back four ops with consumer stalled on cycles 4..6
    for (int i = 0; i < 12; i++) begin
      if (i < 4) drive_op(1'($urandom), pick_operand(), pick_operand());
      else       drive_idle();
      out_ready = !(i >= 4 && i <= 6);
      cycle();
    end
    drain();

    // Flush one cycle after two transfers, with a third op offered on the flush cycle
    drive_op(1'b1, pick_operand(), pick_operand());
    cycle();
    drive_op(1'b0, pick_operand(), pick_operand());
    cycle();
    drive_op(1'b1, pick_operand(), pick_operand());
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    drive_idle();
    repeat (4) cycle();
    drive_op(1'b1, 32'hFFFFFFFD, 32'h00000007);
    cycle();
    drain();

    // Reset in the middle of flight
    drive_op(1'b1, pick_operand(), pick_operand());
    cycle();
    drive_op(1'b0, pick_operand(), pick_operand());
    cycle();
    resetn = 1'b0;
    cycle();
    resetn = 1'b1;
    drive_idle();
    repeat (4) cycle();

`ifdef MULT_ACC_EN
    drive_acc(1'b1, 32'd2, 32'd3, 2'b10, 64'h0000000100000000);
    drv_exp = 64'h00000000FFFFFFFA;
    cycle();
    drive_acc(1'b1, 32'd1, 32'd1, 2'b01, 64'hFFFFFFFFFFFFFFFF);
    drv_exp = 64'h0000000000000000;
    cycle();
    drive_acc(1'b0, 32'd5, 32'd6, 2'b11, 64'h123456789ABCDEF0);
    cycle();
    drain();
`endif

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) != 0) begin
`ifdef MULT_ACC_EN
        drive_acc(1'($urandom), pick_operand(), pick_operand(), 2'($urandom_range(0, 3)),
                  {W'($urandom), W'($urandom)});
`else
        drive_op(1'($urandom), pick_operand(), pick_operand());
`endif
      end else begin
        drive_idle();
      end
      cycle();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
